// File: rtl/mat_pkg.sv
// -----------------------------------------------------------------------------
// mat_pkg
// Shared definitions for the matrix stream I/O block.
//   ELEM_W : element width in bits
//   N      : matrix dimension (N x N)
//   NELEM  : number of elements per matrix (N*N)
//   CNT_W  : width of the element counter (must hold 0..NELEM-1)
//   state_t: controller state encoding
// -----------------------------------------------------------------------------
package mat_pkg;

  localparam int ELEM_W = 8;
  localparam int N      = 3;
  localparam int NELEM  = N * N;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    UNLOAD = 3'd4
  } state_t;

endpackage

// File: rtl/mat_elem_reg.sv
// -----------------------------------------------------------------------------
// mat_elem_reg
// NUM-entry element register with a single indexed write port and a flat,
// always-visible read of all entries (entry i at flat[i*W +: W]).
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset, clears every entry
//   wr_en   : write strobe
//   wr_idx  : entry to write
//   wr_data : element value written
//   flat    : concatenation of all entries, entry 0 in the LSBs
// -----------------------------------------------------------------------------
module mat_elem_reg
  import mat_pkg::*;
#(
  parameter int W     = mat_pkg::ELEM_W,
  parameter int NUM   = mat_pkg::NELEM,
  parameter int IDX_W = CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [W-1:0]       wr_data,
  output logic [NUM*W-1:0]   flat
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_elem
      logic [W-1:0] elem_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          elem_reg <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          elem_reg <= wr_data;
        end
      end

      assign flat[gi*W +: W] = elem_reg;
    end
  endgenerate

endmodule

// File: rtl/mat_stream_io.sv
// -----------------------------------------------------------------------------
// mat_stream_io
// Streams two N x N matrices in (A then B, row-major), hands them to an
// external multiplier with a one-cycle start pulse, captures the result on
// the multiplier's done pulse and streams it out row-major.
// Ports:
//   clk, reset          : clock (rising edge), async active-high reset
//   in_valid/in_data    : upstream element stream
//   in_ready            : high while loading A or B
//   A_flat, B_flat      : assembled operand matrices (element m,n at m*N+n)
//   mm_start            : one-cycle start pulse to the multiplier
//   mm_done, C_flat     : multiplier completion pulse and result
//   out_valid/out_data  : downstream result element stream
//   out_last            : marks the final result element
//   out_ready           : downstream backpressure
//   busy                : low only when idle in LOAD_A with nothing received
// -----------------------------------------------------------------------------
module mat_stream_io #(
  parameter int ELEM_W = mat_pkg::ELEM_W,
  parameter int N      = mat_pkg::N
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [ELEM_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [N*N*ELEM_W-1:0]     A_flat,
  output logic [N*N*ELEM_W-1:0]     B_flat,
  output logic                      mm_start,
  input  logic                      mm_done,
  input  logic [N*N*ELEM_W-1:0]     C_flat,
  output logic                      out_valid,
  output logic [ELEM_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy
);

  import mat_pkg::state_t;
  import mat_pkg::CNT_W;
  import mat_pkg::LOAD_A;
  import mat_pkg::LOAD_B;
  import mat_pkg::START;
  import mat_pkg::WAIT;
  import mat_pkg::UNLOAD;

  localparam int NELEM  = N * N;
  localparam int FLAT_W = NELEM * ELEM_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NELEM - 1);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    cnt_inc;
  logic                in_ready_reg;
  logic                mm_start_reg;
  logic                out_valid_reg;
  logic [ELEM_W-1:0]   out_data_reg;
  logic                out_last_reg;
  logic                busy_reg;
  logic [FLAT_W-1:0]   c_reg;

  logic                in_xfer;
  logic                out_xfer;
  logic                wr_a;
  logic                wr_b;

  // in_ready_reg is only ever high in LOAD_A/LOAD_B, so a transfer implies
  // one of the two load states.
  assign in_xfer  = in_valid && in_ready_reg;
  assign out_xfer = out_valid_reg && out_ready;
  assign cnt_inc  = cnt_reg + CNT_W'(1);
  assign wr_a     = in_xfer && (state_reg == LOAD_A);
  assign wr_b     = in_xfer && (state_reg == LOAD_B);

  // Operand storage: written element by element while loading, untouched
  // otherwise, so the multiplier sees stable operands from START onward.
  mat_elem_reg #(
    .W     (ELEM_W),
    .NUM   (NELEM),
    .IDX_W (CNT_W)
  ) u_a_reg (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_a),
    .wr_idx  (cnt_reg),
    .wr_data (in_data),
    .flat    (A_flat)
  );

  mat_elem_reg #(
    .W     (ELEM_W),
    .NUM   (NELEM),
    .IDX_W (CNT_W)
  ) u_b_reg (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_b),
    .wr_idx  (cnt_reg),
    .wr_data (in_data),
    .flat    (B_flat)
  );

  // Controller with registered outputs. Every output register is updated
  // on the same edge as the state change it belongs to, which gives the
  // single-cycle latencies transfer->mm_start and mm_done->out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= LOAD_A;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b0;
      mm_start_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      c_reg         <= '0;
    end else begin
      case (state_reg)
        LOAD_A: begin
          in_ready_reg <= 1'b1;
          if (in_xfer) begin
            busy_reg <= 1'b1;
            if (cnt_reg == LAST_IDX) begin
              cnt_reg   <= '0;
              state_reg <= LOAD_B;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end

        LOAD_B: begin
          if (in_xfer) begin
            if (cnt_reg == LAST_IDX) begin
              cnt_reg      <= '0;
              state_reg    <= START;
              in_ready_reg <= 1'b0;
              mm_start_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end

        START: begin
          mm_start_reg <= 1'b0;
          state_reg    <= WAIT;
        end

        WAIT: begin
          // C_flat is only guaranteed valid in the done cycle, so the first
          // output element is taken straight from it rather than from c_reg.
          if (mm_done) begin
            c_reg         <= C_flat;
            state_reg     <= UNLOAD;
            out_valid_reg <= 1'b1;
            out_data_reg  <= C_flat[ELEM_W-1:0];
            out_last_reg  <= (LAST_IDX == '0);
          end
        end

        UNLOAD: begin
          if (out_xfer) begin
            if (cnt_reg == LAST_IDX) begin
              cnt_reg       <= '0;
              state_reg     <= LOAD_A;
              out_valid_reg <= 1'b0;
              out_data_reg  <= '0;
              out_last_reg  <= 1'b0;
              in_ready_reg  <= 1'b1;
              busy_reg      <= 1'b0;
            end else begin
              cnt_reg      <= cnt_inc;
              out_data_reg <= c_reg[cnt_inc*ELEM_W +: ELEM_W];
              out_last_reg <= (cnt_inc == LAST_IDX);
            end
          end
        end

        default: begin
          state_reg     <= LOAD_A;
          cnt_reg       <= '0;
          in_ready_reg  <= 1'b1;
          mm_start_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          out_data_reg  <= '0;
          out_last_reg  <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign mm_start  = mm_start_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mat_stream_io.sv
// -----------------------------------------------------------------------------
// tb_mat_stream_io
// Self-checking bench for mat_stream_io. The bench plays upstream source,
// multiplier and downstream sink; expected values come from the element
// arrays handed to each transaction.
// -----------------------------------------------------------------------------
module tb_mat_stream_io;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [71:0] A_flat;
  logic [71:0] B_flat;
  logic        mm_start;
  logic        mm_done = 1'b0;
  logic [71:0] C_flat = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mat_stream_io #(.ELEM_W(8), .N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .A_flat    (A_flat),
    .B_flat    (B_flat),
    .mm_start  (mm_start),
    .mm_done   (mm_done),
    .C_flat    (C_flat),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input logic [7:0] v [9]);
    logic [71:0] r;
    r = '0;
    for (int e = 0; e < 9; e++) r[e*8 +: 8] = v[e];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    mm_done = 1'b0;
    out_ready = 1'b0;
    #2;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_A_flat", A_flat, 0);
    check_eq("rst_B_flat", B_flat, 0);
    check_eq("rst_mm_start", mm_start, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    check_eq("rst_in_ready_held", in_ready, 0);
    tick();
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_busy", busy, 0);
  endtask

  // Present one element, with optional idle gaps before it, and wait for it
  // to be accepted. Returns at #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input int gap_pct);
    int guard;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data = d;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check_eq("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // rdy_mode: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  // abort_at >= 0 resets the DUT after that many result elements.
  task automatic run_txn(input int id, input logic [7:0] a [9], input logic [7:0] b [9],
                         input logic [7:0] c [9], input int gap_pct, input int rdy_mode,
                         input int done_delay, input bit noise, input int abort_at);
    logic [71:0] a_exp, b_exp, c_exp;
    int k, cyc;
    bit acc;
    a_exp = pack9(a);
    b_exp = pack9(b);
    c_exp = pack9(c);

    for (int e = 0; e < 9; e++) send_byte(a[e], gap_pct);
    check_eq("loadb_in_ready", in_ready, 1);
    check_eq("loadb_busy", busy, 1);
    check_eq("loadb_A_flat", A_flat, a_exp);

    for (int e = 0; e < 9; e++) begin
      if (noise && e == 4) begin
        mm_done = 1'b1;
        C_flat = {$urandom, $urandom, 8'hEE};
        tick();
        mm_done = 1'b0;
        check_eq("loadb_done_ignored", in_ready, 1);
        check_eq("loadb_done_no_valid", out_valid, 0);
      end
      if (e == 8) check_eq("pre_start_low", mm_start, 0);
      send_byte(b[e], gap_pct);
    end

    check_eq("start_latency", mm_start, 1);
    check_eq("start_in_ready", in_ready, 0);
    check_eq("A_flat", A_flat, a_exp);
    check_eq("B_flat", B_flat, b_exp);
    tick();
    check_eq("start_width", mm_start, 0);
    repeat (done_delay - 2) tick();
    check_eq("wait_no_valid", out_valid, 0);
    check_eq("wait_busy", busy, 1);

    mm_done = 1'b1;
    C_flat = c_exp;
    tick();
    mm_done = 1'b0;
    C_flat = {$urandom, $urandom, 8'h5A};
    check_eq("done_latency", out_valid, 1);

    k = 0;
    cyc = 0;
    while (k < 9 && k != abort_at && cyc < 300) begin
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'(($urandom_range(99)) < 60);
      endcase
      if (noise && cyc == 2) mm_done = 1'b1;
      else mm_done = 1'b0;
      check_eq("unload_valid", out_valid, 1);
      check_eq("out_data", out_data, c[k]);
      check_eq("out_last", out_last, (k == 8));
      acc = out_valid && out_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    mm_done = 1'b0;
    out_ready = 1'b0;

    if (abort_at >= 0) begin
      do_reset();
      $display("txn %0d aborted after %0d results", id, k);
    end else begin
      check_eq("unload_count", k, 9);
      check_eq("idle_out_valid", out_valid, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_in_ready", in_ready, 1);
      check_eq("A_hold", A_flat, a_exp);
      check_eq("B_hold", B_flat, b_exp);
      $display("txn %0d A=%h B=%h C=%h gap=%0d rdy=%0d dly=%0d noise=%0d", id, a_exp, b_exp,
               c_exp, gap_pct, rdy_mode, done_delay, noise);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] da [9];
    logic [7:0] db [9];
    logic [7:0] dc [9];
    logic [7:0] ra [9];
    logic [7:0] rb [9];
    logic [7:0] rc [9];
    logic [71:0] spec_a, spec_b;

    spec_a = 72'h090807060504030201;
    spec_b = 72'h010203040506070809;
    for (int e = 0; e < 9; e++) begin
      da[e] = 8'(e + 1);
      db[e] = 8'(9 - e);
      dc[e] = 8'(3 + e);
    end

    #1;
    do_reset();

    // Directed: 1..9 / 9..1, result 03..0B, multiplier done after 11 cycles.
    run_txn(0, da, db, dc, 0, 0, 11, 1'b0, -1);
    check_eq("spec_A_flat", A_flat, spec_a);
    check_eq("spec_B_flat", B_flat, spec_b);

    // Backpressure 1,0,0,1 with stray mm_done pulses in LOAD_B and UNLOAD.
    run_txn(1, da, db, dc, 0, 1, 11, 1'b1, -1);

    // Gapped input must assemble identical operands.
    run_txn(2, da, db, dc, 50, 0, 11, 1'b0, -1);
    check_eq("gap_A_flat", A_flat, spec_a);
    check_eq("gap_B_flat", B_flat, spec_b);

    // Abort after five A elements, then a fresh full load.
    for (int e = 0; e < 5; e++) send_byte(8'($urandom), 0);
    check_eq("partial_busy", busy, 1);
    do_reset();
    $display("txn 3 aborted after 5 A elements");
    run_txn(4, da, db, dc, 0, 0, 11, 1'b0, -1);

    // Abort in the middle of unloading.
    run_txn(5, da, db, dc, 0, 0, 6, 1'b0, 3);

    // Randomized transactions.
    for (int t = 6; t < 14; t++) begin
      for (int e = 0; e < 9; e++) begin
        ra[e] = 8'($urandom);
        rb[e] = 8'($urandom);
        rc[e] = 8'($urandom);
      end
      run_txn(t, ra, rb, rc, int'($urandom_range(0, 60)), int'($urandom_range(0, 2)),
              int'($urandom_range(2, 15)), 1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mat_stream_io.md
MAT_STREAM_IO -- requirements
Module: mat_stream_io

Interface
REQ-001 SHALL have parameter ELEM_W, default 8, element width in bits.
REQ-002 SHALL have parameter N, default 3, matrix dimension; NELEM = N*N = 9.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream byte valid.
REQ-006 SHALL have port in_data  input  8  upstream element (A then B, row-major).
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port A_flat  output  72  assembled matrix A to multiplier.
REQ-009 SHALL have port B_flat  output  72  assembled matrix B to multiplier.
REQ-010 SHALL have port mm_start  output  1  one-cycle start pulse to multiplier.
REQ-011 SHALL have port mm_done  input  1  multiplier completion pulse.
REQ-012 SHALL have port C_flat  input  72  multiplier result, valid in the mm_done cycle.
REQ-013 SHALL have port out_valid  output  1  downstream element valid.
REQ-014 SHALL have port out_data  output  8  result element, row-major.
REQ-015 SHALL have port out_last  output  1  high with the 9th result element.
REQ-016 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-017 SHALL have port busy  output  1  high in every state except LOAD_A with count 0.

Function
REQ-018 SHALL implement states LOAD_A, LOAD_B, START, WAIT, UNLOAD, with a 4-bit element counter cnt (0..8).
REQ-019 SHALL set in_ready=1 only in LOAD_A and LOAD_B; a transfer occurs on in_valid&&in_ready.
REQ-020 SHALL write transfer number e (0..8) in LOAD_A to A_flat[e*8 +: 8], and in LOAD_B to B_flat[e*8 +: 8] (element m,n at index m*3+n).
REQ-021 SHALL, on the transfer with cnt=8, reset cnt to 0 and advance LOAD_A->LOAD_B and LOAD_B->START.
REQ-022 SHALL hold A_flat and B_flat stable from leaving LOAD_B until re-entering LOAD_A, then overwrite them per element.
REQ-023 SHALL drive mm_start=1 for exactly the one cycle spent in START, then go to WAIT.
REQ-024 SHALL, in WAIT, capture C_flat into an internal 72-bit register on the cycle mm_done=1 and go to UNLOAD.
REQ-025 SHALL ignore mm_done in every state other than WAIT.
REQ-026 SHALL, in UNLOAD, drive out_valid=1 and out_data = captured element cnt, and set out_last=1 when cnt=8.
REQ-027 SHALL keep out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-028 SHALL increment cnt on out_valid&&out_ready; on the transfer with cnt=8, clear cnt and return to LOAD_A.
REQ-029 SHALL produce latency from the 18th input transfer to mm_start of exactly 1 cycle, and from mm_done to first out_valid of exactly 1 cycle.
REQ-030 SHALL perform no arithmetic on elements; data passes bit-exact.

Reset
REQ-031 SHALL, on reset, set state=LOAD_A, cnt=0, A_flat=0, B_flat=0, captured C=0, in_ready=0 during reset then 1, mm_start=0, out_valid=0, out_data=0, out_last=0, busy=0.
REQ-032 SHALL treat reset asserted in any state (mid-load, WAIT, mid-unload) as a full abort; partial input and result data are discarded.

Structure
REQ-033 SHALL place ELEM_W, N, NELEM and the state encoding in shared package mat_pkg.
REQ-034 SHALL use one sub-module, mat_elem_reg: 9-entry element register with indexed write and flat 72-bit read, instantiated for A and B.

Verification
REQ-035 SHALL cover: stream bytes 1..9 then 9..1 -> A_flat=0x090807060504030201, B_flat=0x010203040506070809, one mm_start pulse one cycle after the 18th transfer.
REQ-036 SHALL cover: model multiplier returns done 11 cycles after start with C_flat=0x0B0A...03 -> out_data sequence 03..0B, out_last only on 0B.
REQ-037 SHALL cover: out_ready toggled 1,0,0,1 per cycle -> no element lost or repeated; out_data held during stalls.
REQ-038 SHALL cover: in_valid gaps during loading -> same A_flat/B_flat as the gap-free case.
REQ-039 SHALL cover: reset asserted after 5 A bytes -> all outputs at reset values; fresh 18-byte load succeeds.
REQ-040 SHALL cover: mm_done pulsed during LOAD_B and UNLOAD -> ignored; state and out_data unchanged.
